instr_decode_ctrl: RTL and testbench

//  Consumer end of the fetch interface: latches instr_out from instruction_fetch into an IF/ID register and decodes it.

---
 rtl/instr_decode_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_ctrl.sv
// IF/ID latch, decode and redirect control for the fetch interface (RUN/RESOLVE/FLUSH).
// Optional feature: define ID_ILLEGAL_TRAP_EN to make undefined opcodes a sticky trap.
module instr_decode_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int RES_TIMEOUT = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_valid,
    output logic        Jump,
    output logic        JumpM,
    output logic        Branch,
    output logic        id_valid,
    output logic [3:0]  opcode,
    output logic [5:0]  rd,
    output logic [5:0]  rs,
    output logic [5:0]  rt,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal_op
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_RESOLVE = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    localparam int SQ_W  = $clog2(FLUSH_DEPTH + 1);
    localparam int TMO_W = $clog2(RES_TIMEOUT + 1);
    localparam logic [SQ_W-1:0]  SQ_FULL  = SQ_W'(FLUSH_DEPTH);
    localparam logic [SQ_W-1:0]  SQ_ONE   = SQ_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RES_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [31:0]      ifid_q, ifid_d;
    logic             ifid_vld_q, ifid_vld_d;
    logic [SQ_W-1:0]  sq_q, sq_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             br_n_q, br_n_d;
    logic             jump_pend_q, jump_pend_d;
    logic             jm_pend_q, jm_pend_d;
    logic             br_pend_q, br_pend_d;
    logic             id_valid_q, id_valid_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [5:0]       rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             illegal_q, illegal_d;

    logic       accept, enter_flush, drop_one;
    logic [3:0] op;
    logic       dec_rw, dec_mr, dec_mw, undef;
    logic       unused_ifid_lo;

    assign accept = instr_valid & ~stall;
    assign op     = ifid_q[31:28];
    assign dec_rw = op inside {OP_ADD, OP_SUB, OP_INC, OP_NEG, OP_LD, OP_SVPC};
    assign dec_mr = op inside {OP_LD, OP_JM};
    assign dec_mw = (op == OP_ST);
    assign undef  = !(op inside {OP_NOP, OP_SVPC, OP_LD, OP_ST, OP_ADD, OP_INC, OP_NEG,
                                 OP_SUB, OP_J, OP_BRZ, OP_JM, OP_BRN});
    assign unused_ifid_lo = ^ifid_q[9:0];

    always_comb begin
        state_d     = state_q;
        ifid_d      = ifid_q;
        ifid_vld_d  = ifid_vld_q;
        sq_d        = sq_q;
        tmo_d       = tmo_q;
        br_n_d      = br_n_q;
        // Pending pulses survive stalled edges and retire on the first unstalled one.
        jump_pend_d = jump_pend_q & stall;
        jm_pend_d   = jm_pend_q & stall;
        br_pend_d   = br_pend_q & stall;
        id_valid_d  = id_valid_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        illegal_d   = illegal_q;
        enter_flush = 1'b0;
        drop_one    = 1'b0;

        case (state_q)
            S_RUN: if (!stall) begin
                ifid_vld_d = accept;
                if (accept) ifid_d = instr_in;
                id_valid_d  = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (ifid_vld_q) begin
                    opcode_d = op;
                    rd_d     = ifid_q[27:22];
                    rs_d     = ifid_q[21:16];
                    rt_d     = ifid_q[15:10];
                    if (TRAP_EN && (undef || illegal_q)) begin
                        illegal_d = 1'b1;
                    end else begin
                        id_valid_d  = 1'b1;
                        reg_write_d = dec_rw;
                        mem_read_d  = dec_mr;
                        mem_write_d = dec_mw;
                        if (op == OP_J || op == OP_JM) begin
                            jump_pend_d = (op == OP_J);
                            jm_pend_d   = (op == OP_JM);
                            enter_flush = 1'b1;
                            drop_one    = accept;
                        end else if (op == OP_BRZ || op == OP_BRN) begin
                            state_d = S_RESOLVE;
                            tmo_d   = '0;
                            br_n_d  = (op == OP_BRN);
                        end
                    end
                end
            end
            S_RESOLVE: begin
                if (!stall) begin
                    id_valid_d  = 1'b0;
                    reg_write_d = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
                if (!stall && flag_valid) begin
                    if (br_n_q ? flag_n : flag_z) begin
                        br_pend_d   = 1'b1;
                        enter_flush = 1'b1;
                        drop_one    = ifid_vld_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_RUN;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_FLUSH: if (!stall) begin
                id_valid_d  = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (instr_valid) begin
                    if (sq_q == SQ_ONE) state_d = S_RUN;
                    sq_d = sq_q - SQ_ONE;
                end
            end
            default: state_d = S_RUN;
        endcase

        // A wrong-path instruction accepted on the redirect edge counts toward the squash.
        if (enter_flush) begin
            ifid_vld_d = 1'b0;
            if (drop_one && SQ_FULL == SQ_ONE) begin
                state_d = S_RUN;
            end else begin
                state_d = S_FLUSH;
                sq_d    = drop_one ? SQ_FULL - SQ_ONE : SQ_FULL;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_RUN;
            ifid_q      <= 32'h0;
            ifid_vld_q  <= 1'b0;
            sq_q        <= '0;
            tmo_q       <= '0;
            br_n_q      <= 1'b0;
            jump_pend_q <= 1'b0;
            jm_pend_q   <= 1'b0;
            br_pend_q   <= 1'b0;
            id_valid_q  <= 1'b0;
            opcode_q    <= 4'h0;
            rd_q        <= 6'h0;
            rs_q        <= 6'h0;
            rt_q        <= 6'h0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ifid_q      <= ifid_d;
            ifid_vld_q  <= ifid_vld_d;
            sq_q        <= sq_d;
            tmo_q       <= tmo_d;
            br_n_q      <= br_n_d;
            jump_pend_q <= jump_pend_d;
            jm_pend_q   <= jm_pend_d;
            br_pend_q   <= br_pend_d;
            id_valid_q  <= id_valid_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            illegal_q   <= illegal_d;
        end
    end

    // Pulses are masked while stalled so fetch never sees a redirect on a held cycle.
    assign Jump      = jump_pend_q & ~stall;
    assign JumpM     = jm_pend_q & ~stall;
    assign Branch    = br_pend_q & ~stall;
    assign id_valid  = id_valid_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

`ifdef ID_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl: reset, decode, J/JM/BRZ/BRN redirects, stall, timeout, illegal.
module tb_instr_decode_ctrl;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] instr_in;
    logic        instr_valid, stall, flag_z, flag_n, flag_valid;
    logic        Jump, JumpM, Branch, id_valid, reg_write, mem_read, mem_write, illegal_op;
    logic [3:0]  opcode;
    logic [5:0]  rd, rs, rt;

    int passed = 0;
    int total  = 0;

    instr_decode_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .stall(stall), .flag_z(flag_z), .flag_n(flag_n), .flag_valid(flag_valid),
        .Jump(Jump), .JumpM(JumpM), .Branch(Branch), .id_valid(id_valid),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .illegal_op(illegal_op)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        Rst_n = 1'b0; instr_in = 32'h0; instr_valid = 1'b0; stall = 1'b0;
        flag_z = 1'b0; flag_n = 1'b0; flag_valid = 1'b0;
        tick; tick;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_jump", {Jump, JumpM, Branch}, 0);
        Rst_n = 1'b1;

        // Test 1: ADD decode, then async reset mid-stream
        instr_in = 32'h4000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("add_opcode", opcode, 4'h4);
        chk("add_rw_valid", {reg_write, id_valid}, 2'b11);
        Rst_n = 1'b0; #1;
        chk("async_rst_outs", {id_valid, reg_write, opcode}, 0);
        Rst_n = 1'b1;
        instr_in = 32'h4143_0800; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("add_fields", {opcode, rd, rs, rt}, {4'h4, 6'd5, 6'd3, 6'd2});
        chk("add_ctl", {id_valid, reg_write, mem_read, mem_write}, 4'b1100);
        tick;
        chk("bubble_id_valid", id_valid, 0);

        // ST then LD back-to-back
        instr_in = 32'h3000_0000; instr_valid = 1'b1; tick;
        instr_in = 32'hE000_0000; tick;
        chk("st_ctl", {opcode, reg_write, mem_read, mem_write}, {4'h3, 3'b001});
        instr_valid = 1'b0; tick;
        chk("ld_ctl", {opcode, reg_write, mem_read, mem_write}, {4'hE, 3'b110});

        // Test 2: J, two squashed, third decoded
        instr_in = 32'h8000_0000; instr_valid = 1'b1; tick;
        instr_in = 32'h4000_0000; tick;
        chk("j_pulse", {Jump, JumpM, Branch}, 3'b100);
        chk("j_fwd", {id_valid, opcode}, {1'b1, 4'h8});
        tick;
        chk("j_one_cycle", Jump, 0);
        chk("j_sq1", id_valid, 0);
        instr_in = 32'h7000_0000; tick;
        chk("j_sq2", id_valid, 0);
        instr_valid = 1'b0; tick;
        chk("j_third", {id_valid, opcode, reg_write}, {1'b1, 4'h7, 1'b1});

        // Test 3a: BRZ taken
        instr_in = 32'h9000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("brz_fwd", {id_valid, opcode, Branch}, {1'b1, 4'h9, 1'b0});
        flag_valid = 1'b1; flag_z = 1'b1; tick;
        flag_valid = 1'b0; flag_z = 1'b0;
        chk("brz_taken", {Branch, id_valid}, 2'b10);
        instr_in = 32'h4000_0000; instr_valid = 1'b1; tick;
        chk("brz_one_cycle", {Branch, id_valid}, 2'b00);
        tick; tick;
        chk("brz_sq_done", id_valid, 0);
        instr_valid = 1'b0; tick;
        chk("brz_after", {id_valid, opcode}, {1'b1, 4'h4});

        // Test 3b: BRZ not taken (flag_n set must not matter)
        instr_in = 32'h9000_0000; instr_valid = 1'b1; tick;
        instr_in = 32'h4000_0000; tick;
        instr_valid = 1'b0;
        chk("brz_nt_fwd", opcode, 4'h9);
        flag_valid = 1'b1; flag_z = 1'b0; flag_n = 1'b1; tick;
        flag_valid = 1'b0; flag_n = 1'b0;
        chk("brz_nt_nobranch", {Branch, id_valid}, 2'b00);
        tick;
        chk("brz_nt_noflush", {Branch, id_valid, opcode}, {2'b01, 4'h4});

        // Test 4: JM held by stall, pulse masked while stalled
        instr_in = 32'h5000_0000; instr_valid = 1'b1; tick;
        instr_in = 32'hA000_0000; tick;
        instr_valid = 1'b0; stall = 1'b1; #1;
        chk("inc_decoded", {opcode, id_valid, reg_write}, {4'h5, 2'b11});
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("jm_stall_hold", {JumpM, opcode, id_valid, reg_write}, {1'b0, 4'h5, 2'b11});
        end
        stall = 1'b0; tick;
        chk("jm_pulse", {Jump, JumpM, Branch, opcode, mem_read, reg_write}, {3'b010, 4'hA, 2'b10});
        stall = 1'b1; #1;
        chk("jm_masked", JumpM, 0);
        tick;
        stall = 1'b0; #1;
        chk("jm_pending", JumpM, 1);
        tick;
        chk("jm_retired", JumpM, 0);
        instr_in = 32'h4000_0000; instr_valid = 1'b1; stall = 1'b1; tick;
        stall = 1'b0; tick; tick; tick;
        instr_valid = 1'b0;
        chk("jm_stall_nodec", id_valid, 0);
        tick;
        chk("jm_after", {id_valid, opcode}, {1'b1, 4'h4});

        // Test 5: BRN timeout
        instr_in = 32'hB000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("brn_fwd", {id_valid, opcode}, {1'b1, 4'hB});
        flag_z = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            chk("brn_tmo_nobranch", Branch, 0);
        end
        instr_in = 32'h4000_0000; instr_valid = 1'b1; tick;
        chk("brn_tmo_edge", {Branch, id_valid}, 2'b00);
        tick;
        instr_valid = 1'b0;
        chk("brn_tmo_load", {Branch, id_valid}, 2'b00);
        tick;
        chk("brn_tmo_run", {Branch, id_valid, opcode}, {2'b01, 4'h4});
        flag_z = 1'b0;

        // BRN taken, with flag_valid first arriving under stall
        instr_in = 32'hB000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        flag_valid = 1'b1; flag_n = 1'b1; stall = 1'b1; tick;
        stall = 1'b0; #1;
        chk("brn_stall_wins", Branch, 0);
        tick;
        flag_valid = 1'b0; flag_n = 1'b0;
        chk("brn_taken", Branch, 1);
        instr_in = 32'h0; instr_valid = 1'b1; tick; tick;
        instr_valid = 1'b0;

        // Test 6: undefined opcode
        instr_in = 32'hC000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
`ifdef ID_ILLEGAL_TRAP_EN
        chk("ill_set", {illegal_op, id_valid}, 2'b10);
        instr_in = 32'h4000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("ill_sticky", {illegal_op, id_valid}, 2'b10);
        instr_in = 32'h8000_0000; instr_valid = 1'b1; tick;
        instr_valid = 1'b0; tick;
        chk("ill_no_jump", {Jump, id_valid, illegal_op}, 3'b001);
`else
        chk("ill_nop", {illegal_op, id_valid, opcode}, {2'b01, 4'hC});
        chk("ill_nop_ctl", {reg_write, mem_read, mem_write}, 3'b000);
`endif
        Rst_n = 1'b0; #1;
        chk("final_rst", {illegal_op, id_valid}, 2'b00);
        Rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
